// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: mode encodings, flag bit
// positions and the packed FIFO entry layout.
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [2:0] {
    MODE_ADD = 3'b000,
    MODE_SUB = 3'b001,
    MODE_NOT = 3'b010,
    MODE_AND = 3'b011,
    MODE_OR  = 3'b100,
    MODE_XOR = 3'b101,
    MODE_LT  = 3'b110,
    MODE_EQ  = 3'b111
  } alu_mode_e;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef struct packed {
    logic [2:0]       mode;
    logic [ALU_W-1:0] result;
    logic [3:0]       flags;
  } alu_entry_t;

  function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                            input logic z, input logic n);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the ALU, the result stage and its consumer.
// master = upstream/downstream driver side, slave = the result stage.
interface alu_result_stage_if #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
);
  logic                 input_valid;
  logic                 output_ready;
  logic [2:0]           input_mode_select;
  logic [WIDTH-1:0]     input_a;
  logic [WIDTH-1:0]     input_b;
  logic [WIDTH-1:0]     input_result;
  logic                 output_valid;
  logic                 input_ready;
  logic [WIDTH-1:0]     output_result;
  logic [2:0]           output_mode;
  logic [3:0]           output_flags;
  logic [CNT_WIDTH-1:0] output_count;
  logic                 output_check_error;

  modport master (
    output input_valid, input_mode_select, input_a, input_b, input_result, input_ready,
    input  output_ready, output_valid, output_result, output_mode, output_flags,
           output_count, output_check_error
  );

  modport slave (
    input  input_valid, input_mode_select, input_a, input_b, input_result, input_ready,
    output output_ready, output_valid, output_result, output_mode, output_flags,
           output_count, output_check_error
  );
endinterface

// File: rtl/alu_result_fifo.sv
// DEPTH-entry synchronous FIFO with wrap-bit pointers; when empty the output
// holds the most recently popped entry.
module alu_result_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IDX_W:0]    r_wr_ptr;
  logic [IDX_W:0]    r_rd_ptr;
  logic [DATA_W-1:0] r_last;

  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign w_wr_idx  = r_wr_ptr[IDX_W-1:0];
  assign w_rd_idx  = r_rd_ptr[IDX_W-1:0];
  assign o_full    = (w_wr_idx == w_rd_idx) && (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  // Full refuses a push even if a pop happens on the same edge.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_last   <= r_mem[w_rd_idx];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  assign o_data = o_empty ? r_last : r_mem[w_rd_idx];

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: derives {C,V,Z,N}, buffers tuples, counts pushes.
// Define ALU_RESULT_CHECK_EN to add the sticky result re-computation checker.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_W,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic               input_clock,
  input  logic               input_reset_n,
  alu_result_stage_if.slave  bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic [WIDTH:0]       w_sum;
  logic                 w_carry;
  logic                 w_ovf;
  logic                 w_a_msb;
  logic                 w_b_msb;
  logic                 w_r_msb;
  alu_entry_t           w_push_entry;
  alu_entry_t           w_head_entry;
  logic [CNT_WIDTH-1:0] r_count;

  assign w_push  = bus.input_valid && !w_full;
  assign w_a_msb = bus.input_a[WIDTH-1];
  assign w_b_msb = bus.input_b[WIDTH-1];
  assign w_r_msb = bus.input_result[WIDTH-1];

  // Carry/overflow only have meaning for add and subtract.
  always_comb begin
    w_sum   = {1'b0, bus.input_a} + {1'b0, bus.input_b};
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (bus.input_mode_select)
      MODE_ADD: begin
        w_carry = w_sum[WIDTH];
        w_ovf   = (w_a_msb == w_b_msb) && (w_r_msb != w_a_msb);
      end
      MODE_SUB: begin
        w_carry = (bus.input_a < bus.input_b);
        w_ovf   = (w_a_msb != w_b_msb) && (w_r_msb != w_a_msb);
      end
      default: begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_push_entry        = '0;
    w_push_entry.mode   = bus.input_mode_select;
    w_push_entry.result = bus.input_result;
    w_push_entry.flags  = pack_flags(w_carry, w_ovf, (bus.input_result == '0), w_r_msb);
  end

  alu_result_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W ($bits(alu_entry_t))
  ) u_fifo (
    .i_clk   (input_clock),
    .i_rst_n (input_reset_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (bus.input_ready),
    .o_data  (w_head_entry),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      r_count <= '0;
    end else if (w_push) begin
      r_count <= r_count + CNT_ONE;
    end
  end

`ifdef ALU_RESULT_CHECK_EN
  logic [WIDTH-1:0] w_expected;
  logic             r_check_error;

  always_comb begin
    w_expected = '0;
    case (bus.input_mode_select)
      MODE_ADD: w_expected = bus.input_a + bus.input_b;
      MODE_SUB: w_expected = bus.input_a - bus.input_b;
      MODE_NOT: w_expected = {{(WIDTH-1){1'b0}}, (bus.input_a == '0)};
      MODE_AND: w_expected = bus.input_a & bus.input_b;
      MODE_OR:  w_expected = bus.input_a | bus.input_b;
      MODE_XOR: w_expected = bus.input_a ^ bus.input_b;
      MODE_LT:  w_expected = {{(WIDTH-1){1'b0}}, (bus.input_a < bus.input_b)};
      MODE_EQ:  w_expected = {{(WIDTH-1){1'b0}}, (bus.input_a == bus.input_b)};
      default:  w_expected = '0;
    endcase
  end

  // Sticky until reset; the mismatching tuple is still buffered.
  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      r_check_error <= 1'b0;
    end else if (w_push && (w_expected != bus.input_result)) begin
      r_check_error <= 1'b1;
    end
  end

  assign bus.output_check_error = r_check_error;
`else
  assign bus.output_check_error = 1'b0;
`endif

  assign bus.output_ready  = !w_full;
  assign bus.output_valid  = !w_empty;
  assign bus.output_result = w_head_entry.result;
  assign bus.output_mode   = w_head_entry.mode;
  assign bus.output_flags  = w_head_entry.flags;
  assign bus.output_count  = r_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: table vectors, handshake corner
// sequences and randomized traffic against a queue-based reference model.
module tb_alu_result_stage;
  localparam int W     = 4;
  localparam int DEPTH = 2;
  localparam int CNTW  = 8;
`ifdef ALU_RESULT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct {
    bit [2:0] mode;
    bit [3:0] result;
    bit [3:0] flags;
  } m_entry_t;

  typedef struct {
    bit [2:0] mode;
    bit [3:0] a;
    bit [3:0] b;
    bit [3:0] r;
    bit [3:0] flags;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  m_entry_t q[$];
  m_entry_t m_last;
  int       m_count;
  bit       m_err;

  alu_result_stage_if #(.WIDTH(W), .CNT_WIDTH(CNTW)) bus();

  alu_result_stage #(.WIDTH(W), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
    .input_clock   (clk),
    .input_reset_n (rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU computed from the mode definitions with plain arithmetic.
  function automatic int alu_ref(input int m, input int a, input int b);
    case (m)
      0: return (a + b) % 16;
      1: return (a - b + 16) % 16;
      2: return (a == 0) ? 1 : 0;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return (a < b) ? 1 : 0;
      default: return (a == b) ? 1 : 0;
    endcase
  endfunction

  function automatic bit [3:0] flags_ref(input int m, input int a, input int b, input int r);
    bit c, v, z, n;
    bit sa, sb, sr;
    sa = (a >= 8);
    sb = (b >= 8);
    sr = (r >= 8);
    c  = 1'b0;
    v  = 1'b0;
    if (m == 0) begin
      c = (a + b) >= 16;
      v = (sa == sb) && (sr != sa);
    end else if (m == 1) begin
      c = (a < b);
      v = (sa != sb) && (sr != sa);
    end
    z = (r == 0);
    n = sr;
    return {c, v, z, n};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit rdy, input int m, input int a, input int b, input int r);
    bus.input_valid       = v;
    bus.input_ready       = rdy;
    bus.input_mode_select = 3'(m);
    bus.input_a           = 4'(a);
    bus.input_b           = 4'(b);
    bus.input_result      = 4'(r);
  endtask

  task automatic model_reset();
    q.delete();
    m_last  = '{mode: 3'd0, result: 4'd0, flags: 4'd0};
    m_count = 0;
    m_err   = 1'b0;
  endtask

  task automatic compare_outputs(input string tag);
    m_entry_t h;
    h = (q.size() > 0) ? q[0] : m_last;
    check({tag, "_valid"}, int'(bus.output_valid), int'(q.size() > 0));
    check({tag, "_ready"}, int'(bus.output_ready), int'(q.size() < DEPTH));
    check({tag, "_result"}, int'(bus.output_result), int'(h.result));
    check({tag, "_mode"}, int'(bus.output_mode), int'(h.mode));
    check({tag, "_flags"}, int'(bus.output_flags), int'(h.flags));
    check({tag, "_count"}, int'(bus.output_count), m_count);
    check({tag, "_chkerr"}, int'(bus.output_check_error), int'(m_err));
  endtask

  // One clock: decide push/pop from pre-edge occupancy, step the model, compare.
  task automatic cycle(input string tag);
    bit       do_push, do_pop;
    m_entry_t e;
    int       m, a, b, r;
    m       = int'(bus.input_mode_select);
    a       = int'(bus.input_a);
    b       = int'(bus.input_b);
    r       = int'(bus.input_result);
    do_push = bus.input_valid && (q.size() < DEPTH);
    do_pop  = bus.input_ready && (q.size() > 0);
    @(posedge clk);
    #1;
    if (do_pop) m_last = q.pop_front();
    if (do_push) begin
      e.mode   = 3'(m);
      e.result = 4'(r);
      e.flags  = flags_ref(m, a, b, r);
      q.push_back(e);
      m_count = (m_count + 1) % (1 << CNTW);
      if (CHECK_EN && (alu_ref(m, a, b) != r)) m_err = 1'b1;
      $display("%s push mode=%0d a=%0d b=%0d r=%0d flags=%b count=%0d", tag, m, a, b, r, e.flags, m_count);
    end
    compare_outputs(tag);
  endtask

  vec_t tbl[9];
  int   base;

  initial begin
    tbl[0] = '{3'd0, 4'd7,  4'd9,  4'd0,  4'b1010};
    tbl[1] = '{3'd0, 4'd7,  4'd1,  4'd8,  4'b0101};
    tbl[2] = '{3'd1, 4'd3,  4'd5,  4'd14, 4'b1001};
    tbl[3] = '{3'd1, 4'd8,  4'd1,  4'd7,  4'b0100};
    tbl[4] = '{3'd3, 4'd12, 4'd10, 4'd8,  4'b0001};
    tbl[5] = '{3'd6, 4'd3,  4'd9,  4'd1,  4'b0000};
    tbl[6] = '{3'd7, 4'd5,  4'd6,  4'd0,  4'b0010};
    tbl[7] = '{3'd5, 4'd15, 4'd15, 4'd0,  4'b0010};
    tbl[8] = '{3'd0, 4'd8,  4'd8,  4'd0,  4'b1110};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(bus.output_valid), 0);
    check("rst_ready", int'(bus.output_ready), 1);
    check("rst_count", int'(bus.output_count), 0);
    check("rst_result", int'(bus.output_result), 0);
    check("rst_flags", int'(bus.output_flags), 0);
    check("rst_chkerr", int'(bus.output_check_error), 0);
    rst_n = 1'b1;

    // Table vectors streamed back to back with the consumer always ready.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].r);
      cycle("tbl");
      check("tbl_flags", int'(bus.output_flags), int'(tbl[i].flags));
      check("tbl_result", int'(bus.output_result), int'(tbl[i].r));
    end
    drive(1'b0, 1'b1, 0, 0, 0, 0);
    cycle("drain");

    // Back-pressure: third tuple refused while full.
    base = m_count;
    drive(1'b1, 1'b0, 4, 1, 2, 3);
    cycle("bp");
    check("bp_ready_after1", int'(bus.output_ready), 1);
    drive(1'b1, 1'b0, 4, 4, 1, 5);
    cycle("bp");
    check("bp_ready_after2", int'(bus.output_ready), 0);
    drive(1'b1, 1'b0, 4, 6, 1, 7);
    cycle("bp");
    check("bp_count", int'(bus.output_count), (base + 2) % 256);
    check("bp_head1", int'(bus.output_result), 3);
    drive(1'b0, 1'b1, 0, 0, 0, 0);
    cycle("bp_pop");
    check("bp_head2", int'(bus.output_result), 5);
    cycle("bp_pop");
    check("bp_empty_valid", int'(bus.output_valid), 0);
    check("bp_hold_last", int'(bus.output_result), 5);

    // Concurrent push and pop at occupancy 1.
    base = m_count;
    drive(1'b1, 1'b0, 5, 9, 3, 10);
    cycle("cc");
    drive(1'b1, 1'b1, 3, 6, 3, 2);
    cycle("cc");
    check("cc_valid", int'(bus.output_valid), 1);
    check("cc_ready", int'(bus.output_ready), 1);
    check("cc_head", int'(bus.output_result), 2);
    check("cc_count", int'(bus.output_count), (base + 2) % 256);
    drive(1'b0, 1'b1, 0, 0, 0, 0);
    cycle("drain");

    // Wrong AND result: error rises and stays with later correct tuples.
    drive(1'b1, 1'b1, 3, 12, 10, 9);
    cycle("chk");
    check("chk_stored", int'(bus.output_result), 9);
`ifdef ALU_RESULT_CHECK_EN
    check("chk_set", int'(bus.output_check_error), 1);
`else
    check("chk_tied", int'(bus.output_check_error), 0);
`endif
    drive(1'b1, 1'b1, 3, 12, 10, 8);
    cycle("chk");
`ifdef ALU_RESULT_CHECK_EN
    check("chk_sticky", int'(bus.output_check_error), 1);
`else
    check("chk_tied2", int'(bus.output_check_error), 0);
`endif

    for (int i = 0; i < 300; i++) begin
      int m, a, b, r;
      m = int'($urandom_range(0, 7));
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : alu_ref(m, a, b);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, m, a, b, r);
      cycle("rnd");
    end

    // Asynchronous reset with two tuples buffered.
    drive(1'b0, 1'b1, 0, 0, 0, 0);
    repeat (3) cycle("drain");
    drive(1'b1, 1'b0, 2, 0, 5, 1);
    cycle("pre_rst");
    drive(1'b1, 1'b0, 0, 3, 4, 7);
    cycle("pre_rst");
    check("pre_rst_full", int'(bus.output_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", int'(bus.output_valid), 0);
    check("arst_ready", int'(bus.output_ready), 1);
    check("arst_count", int'(bus.output_count), 0);
    check("arst_result", int'(bus.output_result), 0);
    check("arst_flags", int'(bus.output_flags), 0);
    check("arst_chkerr", int'(bus.output_check_error), 0);
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_outputs("post_rst");

    // 256 accepted pushes wrap the counter to zero.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, i % 8, i % 16, (i / 16) % 16, alu_ref(i % 8, i % 16, (i / 16) % 16));
      cycle("wrap");
    end
    check("count_wrap", int'(bus.output_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered output stage directly downstream of the 4-bit 8-function combinational ALU. Each cycle it samples the ALU's operands, mode and result under a valid/ready handshake and derives status flags. It buffers the tuples in a small FIFO so the display or test driver downstream can back-pressure without losing results. It also keeps a count of accepted operations.

Parameters:
WIDTH, 4, operand/result width in bits
DEPTH, 2, FIFO entries (power of two, 2..8)
CNT_WIDTH, 8, width of accepted-operation counter

Ports:
input_clock  in  1  sole clock, rising edge
input_reset_n  in  1  asynchronous active-low reset
input_valid  in  1  upstream tuple valid
output_ready  out  1  stage can accept (= !full)
input_mode_select  in  3  ALU mode the result was produced with
input_a  in  WIDTH  ALU operand A
input_b  in  WIDTH  ALU operand B
input_result  in  WIDTH  ALU result, captured verbatim
output_valid  out  1  head entry valid (= !empty)
input_ready  in  1  downstream accepts head
output_result  out  WIDTH  head result
output_mode  out  3  head mode
output_flags  out  4  head flags {C,V,Z,N} = bits [3:0]
output_count  out  CNT_WIDTH  accepted tuples since reset
output_check_error  out  1  sticky result-mismatch flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-low): FIFO emptied, pointers and count cleared; output_valid=0, output_ready=1, output_result/mode/flags=0, output_count=0, output_check_error=0. Reset mid-operation drops all buffered tuples; no partial entry survives.
- Push: rising edge with input_valid && output_ready stores {mode, result, flags}; output_count increments.
- Pop: rising edge with output_valid && input_ready advances head.
- Latency: tuple pushed at edge N is visible on outputs after edge N when the FIFO was empty. There is no combinational input-to-output path.
- output_ready depends only on the registered full state, never on input_ready. A full FIFO refuses a push even when a pop occurs in the same cycle.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, both take effect.
- Pointers are log2(DEPTH) bits plus one wrap bit: full = indices equal and wrap bits differ; empty = indices and wrap bits equal.
- Outputs present head entry contents. When empty, output_result/mode/flags hold the last popped value; consumers must qualify with output_valid.
- Flags are computed at push time from input_a/b/mode/result:
  - Mode 000 (add): C = carry-out of the (WIDTH+1)-bit sum a+b; V = a[W-1]==b[W-1] && result[W-1]!=a[W-1].
  - Mode 001 (sub): C = borrow (a < b unsigned); V = a[W-1]!=b[W-1] && result[W-1]!=a[W-1].
  - All other modes: C=0, V=0.
  - Z = (result == 0); N = result[W-1], for all modes.
- output_count wraps from 2^CNT_WIDTH-1 to 0. Only accepted pushes count.
- Inputs are ignored while output_ready=0.

Optional Feature:
- Macro ALU_RESULT_CHECK_EN.
- Defined: on each push the stage recomputes the expected result from a, b and mode, truncated to WIDTH:
  - add/sub wrap;
  - mode 010 = logical NOT (1 if a==0 else 0);
  - 110 = (a<b unsigned);
  - 111 = (a==b);
  - others bitwise.
  - A mismatch with input_result sets output_check_error; it stays set until reset. The tuple is still stored.
- Undefined: checker logic absent; output_check_error tied to 0.

Decomposition:
- Shared package alu_pkg holds:
  - mode encoding constants (MODE_ADD=000 … MODE_EQ=111);
  - flag bit indices (FLAG_C=3, FLAG_V=2, FLAG_Z=1, FLAG_N=0);
  - the packed entry typedef {mode, result, flags}.
- One sub-module: alu_result_fifo, a parameterised DEPTH-entry synchronous FIFO with full/empty and asynchronous active-low reset.
- Flag generation and the checker stay inline in alu_result_stage.

Test Plan:
- Reset: hold input_reset_n=0 mid-stream with 2 entries buffered -> output_valid=0, output_ready=1, output_count=0 immediately (asynchronous).
- Add: a=7, b=9, mode=000, result=0 -> flags C=1, V=0, Z=1, N=0 after one edge; a=7, b=1, result=8 -> C=0, V=1, Z=0, N=1.
- Sub: a=3, b=5, mode=001, result=14 -> C=1 (borrow), V=0, N=1, Z=0; a=8, b=1, result=7 -> V=1, C=0.
- Back-pressure: input_ready=0 while pushing 3 tuples with DEPTH=2 -> output_ready falls after 2nd push, 3rd not counted (output_count=2). Release input_ready -> tuples emerge in order.
- Concurrent: occupancy 1, push and pop same edge -> occupancy stays 1, new head equals 2nd tuple, count +1. Count wrap: 256 pushes -> output_count=0.
- With ALU_RESULT_CHECK_EN: push mode=011, a=12, b=10, result=9 (expected 8) -> output_check_error=1 and stays 1. Later correct tuples leave it set; reset clears it.
